// File: rtl/mips_pkg.sv
// Shared widths, control-word bit positions and the operand bypass helper
// used by the ID/EX pipeline stage.
package mips_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  // ctrl = {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[1:0]}
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_MEM_READ   = 5;
  localparam int CTRL_MEM_WRITE  = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_REG_DST    = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  // $zero always reads 0; a same-cycle writeback wins over the stale file value.
  function automatic logic [DATA_W-1:0] bypass_operand(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] rf_data,
    input logic              wb_we,
    input logic [REG_W-1:0]  wb_reg,
    input logic [DATA_W-1:0] wb_data
  );
    if (src == '0)
      return '0;
    else if (wb_we && (wb_reg == src))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the instruction in decode needs a register that
// the load currently sitting in the ID/EX register has not produced yet.
import mips_pkg::*;

module hazard_detect (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             hazard
);

  always_comb begin
    hazard = ex_valid && ex_mem_read && (ex_dest != '0) &&
             ((uses_rs && (rs == ex_dest)) || (uses_rt && (rt == ex_dest)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush, downstream backpressure and a saturating bubble counter.
import mips_pkg::*;

module id_ex_stage #(
  // Counter saturation point; overridable so short runs can reach it.
  parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] imm,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_dest,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [15:0]       stall_cnt
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [REG_W-1:0]  dest_q, dest_d, rs_q, rs_d, rt_q, rt_d;
  logic [15:0]       stall_q, stall_d;
  logic              hazard;
  logic              hold;

  hazard_detect u_hazard (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
    .ex_dest     (dest_q),
    .uses_rs     (uses_rs),
    .uses_rt     (uses_rt),
    .rs          (rs),
    .rt          (rt),
    .hazard      (hazard)
  );

  always_comb begin
    hold     = valid_q && !ex_ready;
    in_ready = !rst && (flush || (!hazard && (!valid_q || ex_ready)));
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    dest_d  = dest_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    stall_d = stall_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (hazard && in_valid) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (stall_q != STALL_MAX)
        stall_d = stall_q + 16'd1;
    end else if (in_valid) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl;
      a_d     = bypass_operand(rs, rdata1, wb_we, wb_reg, wb_data);
      b_d     = bypass_operand(rt, rdata2, wb_we, wb_reg, wb_data);
      imm_d   = imm;
      dest_d  = ctrl[CTRL_REG_DST] ? rd : rt;
      rs_d    = rs;
      rt_d    = rt;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      dest_q  <= dest_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    out_valid = valid_q;
    out_ctrl  = ctrl_q;
    out_a     = a_q;
    out_b     = b_q;
    out_imm   = imm_q;
    out_dest  = dest_q;
    out_rs    = rs_q;
    out_rt    = rt_q;
    stall_cnt = stall_q;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  in  1  single clock, all state updates on posedge clk.
REQ-002 SHALL: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL: in_valid  in  1  decode stage presents a valid instruction.
REQ-004 SHALL: in_ready  out  1  stage accepts the presented instruction this cycle.
REQ-005 SHALL: rs, rt, rd  in  5 each  decoded register addresses.
REQ-006 SHALL: rdata1, rdata2  in  32 each  register-file read data for rs and rt (asynchronous read).
REQ-007 SHALL: imm  in  32  sign-extended immediate.
REQ-008 SHALL: ctrl  in  8  {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, alu_op[1:0]}.
REQ-009 SHALL: uses_rs, uses_rt  in  1 each  instruction actually reads rs / rt.
REQ-010 SHALL: wb_we, wb_reg(5), wb_data(32)  in  writeback port, identical to the register-file write port.
REQ-011 SHALL: flush  in  1  taken branch/jump; kill the held instruction.
REQ-012 SHALL: ex_ready  in  1  execute stage consumes out_* this cycle.
REQ-013 SHALL: out_valid(1), out_ctrl(8), out_a(32), out_b(32), out_imm(32), out_dest(5), out_rs(5), out_rt(5)  out  registered payload.
REQ-014 SHALL: stall_cnt  out  16  saturating count of load-use bubble cycles.

Function
REQ-015 SHALL: bypass A = 0 if rs==0; else wb_data if wb_we && wb_reg==rs; else rdata1 (covers same-cycle write not yet visible to the register file).
REQ-016 SHALL: bypass B identically for rt/rdata2.
REQ-017 SHALL: out_dest = rd when ctrl.reg_dst=1, else rt, captured at load.
REQ-018 SHALL: hazard = out_valid && out_ctrl.mem_read && out_dest!=0 && ((uses_rs && rs==out_dest) || (uses_rt && rt==out_dest)).
REQ-019 SHALL: in_ready = flush || (!hazard && (!out_valid || ex_ready)), combinational.
REQ-020 SHALL: next-state priority per cycle: flush -> out_valid<=0; else hold (out_valid && !ex_ready) -> all out_* unchanged; else hazard && in_valid -> bubble (out_valid<=0, out_ctrl<=0); else in_valid -> load all out_*, out_valid<=1; else out_valid<=0.
REQ-021 SHALL: a bubble lasts exactly one cycle per load-use pair; instruction then loads with bypassed data next cycle.
REQ-022 SHALL: flush during a stall discards the stalled instruction; in_ready=1 that cycle and the input is dropped.
REQ-023 SHALL: out_ctrl is forced to 0 whenever out_valid is 0 so downstream never writes.
REQ-024 SHALL: stall_cnt increments by 1 on each bubble cycle, saturating at 16'hFFFF, never wrapping.
REQ-025 SHALL: latency ID-to-EX is one cycle when no stall/hold.

Reset
REQ-026 SHALL: on rst=1 at posedge: out_valid=0, all out_* payload=0, stall_cnt=0.
REQ-027 SHALL: rst has priority over flush, hold and load; in_ready=0 while rst=1.

Structure
REQ-028 SHALL: ctrl bit indices, register-address width (5) and data width (32) live in shared package mips_pkg.
REQ-029 SHALL: load-use detection is a combinational sub-module hazard_detect; bypass and pipeline register stay in id_ex_stage.

Verification
REQ-030 SHALL: reset mid-stream: hold rst 1 cycle with out_valid=1 -> next cycle out_valid=0, out_a=0, stall_cnt=0.
REQ-031 SHALL: lw $8 then add $9,$8,$8 -> one bubble (out_valid=0, in_ready=0), add issues next cycle, stall_cnt=1.
REQ-032 SHALL: wb_we=1, wb_reg=5, wb_data=32'hDEADBEEF, rs=5, rdata1=0 -> out_a=32'hDEADBEEF; wb_reg=0 with rs=0 -> out_a=0.
REQ-033 SHALL: ex_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0; ex_ready=1 -> next instruction loads.
REQ-034 SHALL: flush asserted during load-use stall -> out_valid=0 next cycle, stalled instruction never appears on out_*.
REQ-035 SHALL: force 65536 bubbles -> stall_cnt=16'hFFFF and stays there.
